// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array feeder blocks.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

  // Drain counter must hold N-1 down to 0.
  function automatic int drain_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain carrying one lane's element and its valid bit.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  v_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  v_out
);

  logic [DEPTH:1][DATA_WIDTH-1:0] dat_pipe;
  logic [DEPTH:1]                 vld_pipe;

  // Data is zeroed whenever its stage is invalid so bubbles reach the mesh as 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dat_pipe <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= v_in;
      dat_pipe[1] <= v_in ? d_in : '0;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= vld_pipe[i-1] ? dat_pipe[i-1] : '0;
      end
    end
  end

  assign d_out = dat_pipe[DEPTH];
  assign v_out = vld_pipe[DEPTH];

endmodule

// File: rtl/systolic_input_skew.sv
// Mesh feeder: accepts row vectors, skews lane r by r cycles, counts the pass
// and pulses done as the last element enters lane N-1.
module systolic_input_skew
  import systolic_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CNT_WIDTH-1:0]         cfg_len,
  input  logic                         cfg_valid,
  input  logic [N-1:0][DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N-1:0][DATA_WIDTH-1:0] sys_data_in,
  output logic [N-1:0]                 sys_start,
  output logic                         busy,
  output logic                         done
);

  localparam int DRW = drain_width(N);

  skew_state_e          state_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic [DRW-1:0]       drain_q;
  logic                 last_q;   // N==1 completion, done one cycle after last accept
  logic                 zero_q;   // zero-length pass completion
  logic                 accept;
  logic                 drain_done;
  logic                 cfg_ok;

  assign in_ready   = (state_q == STREAM);
  assign accept     = in_valid && in_ready;
  assign drain_done = (state_q == DRAIN) && (drain_q == '0);
  assign done       = drain_done || last_q || zero_q;
  assign busy       = (state_q != IDLE) || last_q;
  assign cfg_ok     = cfg_valid && (state_q == IDLE) && !done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      drain_q <= '0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      last_q <= 1'b0;
      zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_ok) begin
            if (cfg_len != '0) begin
              rem_q   <= cfg_len;
              state_q <= STREAM;
            end else begin
              zero_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept && rem_q != '0) begin
            rem_q <= rem_q - CNT_WIDTH'(1);
            if (rem_q == CNT_WIDTH'(1)) begin
              if (N == 1) begin
                state_q <= IDLE;
                last_q  <= 1'b1;
              end else begin
                state_q <= DRAIN;
                drain_q <= DRW'(N - 1);
              end
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) state_q <= IDLE;
          else               drain_q <= drain_q - DRW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lane r gets r+1 flops so a vector accepted at t appears on lane r at t+1+r.
  for (genvar r = 0; r < N; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH      (r + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_dl (
      .clk   (clk),
      .rst   (rst),
      .d_in  (in_data[r]),
      .v_in  (accept),
      .d_out (sys_data_in[r]),
      .v_out (sys_start[r])
    );
  end

endmodule

// File: tb/tb_systolic_input_skew.sv
// Self-checking bench: directed vector tables, hand-written corner sequences
// and randomized traffic against a cycle-indexed reference model.
module tb_systolic_input_skew;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int VW = N * DW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [CW-1:0]        cfg_len = '0;
  logic                 cfg_valid = 1'b0;
  logic [N-1:0][DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready, busy, done;
  logic [N-1:0][DW-1:0] sys_data_in;
  logic [N-1:0]         sys_start;

  systolic_input_skew #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_valid(cfg_valid),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sys_data_in(sys_data_in), .sys_start(sys_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: expected lane outputs scheduled into a ring by cycle.
  logic [N-1:0]         ring_s [64];
  logic [N-1:0][DW-1:0] ring_d [64];
  bit m_stream = 0, m_pass = 0;
  int m_rem = 0;
  int m_done_cyc = -1;

  initial for (int i = 0; i < 64; i++) begin ring_s[i] = '0; ring_d[i] = '0; end

  task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [N-1:0][DW-1:0] mkvec(input int base);
    logic [N-1:0][DW-1:0] v;
    for (int r = 0; r < N; r++) v[r] = DW'(base + r);
    return v;
  endfunction

  task automatic model_check();
    int slot;
    bit e_rdy, e_busy, e_done, n_stream, n_pass;
    slot   = cyc % 64;
    e_rdy  = m_stream;
    e_busy = m_pass;
    e_done = (cyc == m_done_cyc);
    chk("m_ready", VW'(in_ready), VW'(e_rdy));
    chk("m_busy",  VW'(busy),     VW'(e_busy));
    chk("m_done",  VW'(done),     VW'(e_done));
    chk("m_start", VW'(sys_start), VW'(ring_s[slot]));
    chk("m_data",  sys_data_in,   ring_d[slot]);
    ring_s[slot] = '0;
    ring_d[slot] = '0;
    if (!rst) begin
      m_stream = 0; m_pass = 0; m_done_cyc = -1;
      for (int i = 0; i < 64; i++) begin ring_s[i] = '0; ring_d[i] = '0; end
    end else begin
      n_stream = m_stream;
      n_pass   = m_pass;
      if (m_stream && in_valid) begin
        for (int r = 0; r < N; r++) begin
          ring_s[(cyc + 1 + r) % 64][r] = 1'b1;
          ring_d[(cyc + 1 + r) % 64][r] = in_data[r];
        end
        m_rem--;
        if (m_rem == 0) begin n_stream = 0; m_done_cyc = cyc + N; end
      end
      if (m_pass && cyc == m_done_cyc) n_pass = 0;
      if (!m_pass && !e_done && cfg_valid) begin
        if (cfg_len != 0) begin n_pass = 1; n_stream = 1; m_rem = int'(cfg_len); end
        else m_done_cyc = cyc + 1;
      end
      m_stream = n_stream;
      m_pass   = n_pass;
    end
    cyc++;
  endtask

  // One clock cycle: inputs just after the edge, outputs checked at the falling edge.
  task automatic drive(input bit cv, input int len, input bit iv,
                       input logic [N-1:0][DW-1:0] d, input bit r);
    @(posedge clk); #1;
    cfg_valid = cv; cfg_len = CW'(len); in_valid = iv; in_data = d; rst = r;
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    bit cv; int len; bit iv; int base;
    bit rdy; bit bsy; bit dn; bit s0; int d0; bit s3; int d3;
  } row_t;
  row_t tbl [23];

  int acc_n, done_n;
  bit done_seen;

  initial begin
    // Scenario A: three back-to-back vectors. Scenario B: bubble in the second slot.
    tbl[0]  = '{0,0,0,0,       0,0,0, 0,0, 0,0};
    tbl[1]  = '{1,3,1,'hDEAD,  0,0,0, 0,0, 0,0};
    tbl[2]  = '{0,0,1,1,       1,1,0, 0,0, 0,0};
    tbl[3]  = '{0,0,1,5,       1,1,0, 1,1, 0,0};
    tbl[4]  = '{0,0,1,9,       1,1,0, 1,5, 0,0};
    tbl[5]  = '{0,0,1,'h100,   0,1,0, 1,9, 0,0};
    tbl[6]  = '{0,0,0,0,       0,1,0, 0,0, 1,4};
    tbl[7]  = '{0,0,0,0,       0,1,0, 0,0, 1,8};
    tbl[8]  = '{0,0,0,0,       0,1,1, 0,0, 1,12};
    tbl[9]  = '{0,0,0,0,       0,0,0, 0,0, 0,0};
    tbl[10] = '{0,0,0,0,       0,0,0, 0,0, 0,0};
    tbl[11] = '{0,0,0,0,       0,0,0, 0,0, 0,0};
    tbl[12] = '{1,3,0,0,       0,0,0, 0,0, 0,0};
    tbl[13] = '{0,0,1,1,       1,1,0, 0,0, 0,0};
    tbl[14] = '{0,0,0,'h77,    1,1,0, 1,1, 0,0};
    tbl[15] = '{0,0,1,5,       1,1,0, 0,0, 0,0};
    tbl[16] = '{0,0,1,9,       1,1,0, 1,5, 0,0};
    tbl[17] = '{0,0,0,0,       0,1,0, 1,9, 1,4};
    tbl[18] = '{0,0,0,0,       0,1,0, 0,0, 0,0};
    tbl[19] = '{0,0,0,0,       0,1,0, 0,0, 1,8};
    tbl[20] = '{0,0,0,0,       0,1,1, 0,0, 1,12};
    tbl[21] = '{0,0,0,0,       0,0,0, 0,0, 0,0};
    tbl[22] = '{0,0,0,0,       0,0,0, 0,0, 0,0};

    drive(0, 0, 0, '0, 0);
    drive(0, 0, 0, '0, 0);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].cv, tbl[i].len, tbl[i].iv, mkvec(tbl[i].base), 1);
      chk("tbl_ready", VW'(in_ready), VW'(tbl[i].rdy));
      chk("tbl_busy",  VW'(busy),     VW'(tbl[i].bsy));
      chk("tbl_done",  VW'(done),     VW'(tbl[i].dn));
      chk("tbl_s0",    VW'(sys_start[0]),   VW'(tbl[i].s0));
      chk("tbl_d0",    VW'(sys_data_in[0]), VW'(tbl[i].d0));
      chk("tbl_s3",    VW'(sys_start[3]),   VW'(tbl[i].s3));
      chk("tbl_d3",    VW'(sys_data_in[3]), VW'(tbl[i].d3));
    end

    // Zero-length pass; a cfg_valid during the done cycle must be dropped.
    drive(1, 0, 0, '0, 1);
    drive(1, 0, 0, '0, 1);
    chk("zero_done",  VW'(done), VW'(1));
    chk("zero_busy",  VW'(busy), VW'(0));
    chk("zero_ready", VW'(in_ready), VW'(0));
    chk("zero_start", VW'(sys_start), VW'(0));
    drive(0, 0, 0, '0, 1);
    chk("zero_cfg_in_done_ignored", VW'(done | busy), VW'(0));

    // cfg_valid mid-stream with a different length is ignored.
    acc_n = 0; done_n = 0;
    drive(1, 4, 0, '0, 1);
    for (int i = 0; i < 14; i++) begin
      drive(i == 1, 2, 1, mkvec(100 + 8 * i), 1);
      if (in_ready && in_valid) acc_n++;
      if (done) done_n++;
    end
    chk("recfg_accepts", VW'(acc_n), VW'(4));
    chk("recfg_dones",   VW'(done_n), VW'(1));

    // Reset while three vectors are in flight.
    drive(1, 5, 0, '0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, mkvec(200 + 4 * i), 1);
    drive(0, 0, 1, mkvec(300), 0);
    drive(0, 0, 0, '0, 1);
    chk("rst_start", VW'(sys_start), VW'(0));
    chk("rst_data",  sys_data_in, '0);
    chk("rst_busy",  VW'(busy), VW'(0));
    chk("rst_ready", VW'(in_ready), VW'(0));
    done_seen = done;
    for (int i = 0; i < N + 4; i++) begin
      drive(0, 0, 0, '0, 1);
      done_seen |= done;
    end
    chk("rst_no_done", VW'(done_seen), VW'(0));

    // in_valid in IDLE is ignored.
    for (int i = 0; i < N + 2; i++) begin
      drive(0, 0, 1, mkvec('hDEAD), 1);
      chk("idle_ready", VW'(in_ready), VW'(0));
      chk("idle_start", VW'(sys_start), VW'(0));
    end

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0][DW-1:0] v;
      for (int r = 0; r < N; r++) v[r] = $urandom;
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 6),
            $urandom_range(0, 9) < 7, v, $urandom_range(0, 199) != 0);
    end
    for (int i = 0; i < 2 * N + 8; i++) drive(0, 0, 0, '0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
